// File: rtl/ddc_pkg.sv
// Shared types and constants for the AD/DDC timing chain.
// Holds the scheduler state encoding and the accepted work modes.
package ddc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TX,
        GAP,
        RX
    } state_e;

    localparam logic [7:0] MODE1 = 8'h01;
    localparam logic [7:0] MODE2 = 8'h02;
    localparam logic [7:0] MODE3 = 8'h03;

    function automatic logic mode_ok(input logic [7:0] m);
        return (m == MODE1) || (m == MODE2) || (m == MODE3);
    endfunction

endpackage

// File: rtl/seg_timer.sv
// Loadable down-counter timing one scheduler segment.
// done is high for the single cycle in which the count sits at 1.
module seg_timer #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] value,
    output logic          done
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == CW'(1));

endmodule

// File: rtl/pri_sched.sv
// Per-PRI scheduler: TX gate, receive window and CPI markers.
// Sequences IDLE->TX->GAP->RX on each accepted PRI edge.
module pri_sched
    import ddc_pkg::*;
#(
    parameter int TX_UNIT = 100,
    parameter int RX_DLY  = 200,
    parameter int RX_LEN  = 4000,
    parameter int CW      = 16
) (
    input  logic        glb_100M,
    input  logic        rst_n,
    input  logic        PRI,
    input  logic        flag,
    input  logic [7:0]  work_mode,
    input  logic [7:0]  wave_code,
    input  logic [15:0] pri_code,
    output logic        tx_gate,
    output logic        rx_win,
    output logic        cpi_st,
    output logic        cpi_end,
    output logic [15:0] pri_idx,
    output logic        overrun,
    output logic        hdr_err,
    output logic        busy
);

    if (255 * TX_UNIT >= 2 ** CW) begin : g_len_chk
        $error("pri_sched: 255*TX_UNIT does not fit in CW bits");
    end

    localparam logic [CW-1:0] GAP_CYC = CW'((RX_DLY < 1) ? 1 : RX_DLY);
    localparam logic [CW-1:0] RX_CYC  = CW'((RX_LEN < 1) ? 1 : RX_LEN);

    state_e      state_q, state_d;
    logic        pri_d_q;
    logic [7:0]  wc_q, wc_d;
    logic [15:0] cpi_len_q, cpi_len_d;
    logic [15:0] pri_idx_q, pri_idx_d;
    logic        tx_gate_q, tx_gate_d;
    logic        rx_win_q, rx_win_d;
    logic        cpi_st_q, cpi_st_d;
    logic        cpi_end_q, cpi_end_d;
    logic        overrun_q, overrun_d;
    logic        hdr_err_q, hdr_err_d;
    logic        busy_q, busy_d;

    logic          pri_edge;
    logic [15:0]   idx_inc;
    logic [15:0]   tx_prod;
    logic          seg_load;
    logic [CW-1:0] seg_val;
    logic          seg_done;

    always_comb begin
        state_d   = state_q;
        wc_d      = wc_q;
        cpi_len_d = cpi_len_q;
        pri_idx_d = pri_idx_q;
        hdr_err_d = 1'b0;
        cpi_end_d = 1'b0;
        pri_edge  = PRI & ~pri_d_q;
        idx_inc   = pri_idx_q + 16'd1;

        unique case (state_q)
            IDLE: begin
                if (pri_edge) begin
                    if (!flag && mode_ok(work_mode)) begin
                        state_d = TX;
                        wc_d    = wave_code;
                        if (pri_idx_q == '0) begin
                            cpi_len_d = (pri_code == '0) ? 16'd1 : pri_code;
                        end
                    end else begin
                        hdr_err_d = 1'b1;
                        pri_idx_d = '0;
                    end
                end
            end
            TX: begin
                if (seg_done) state_d = GAP;
            end
            GAP: begin
                if (seg_done) state_d = RX;
            end
            RX: begin
                if (seg_done) begin
                    state_d = IDLE;
                    if (idx_inc == cpi_len_q) begin
                        pri_idx_d = '0;
                        cpi_end_d = 1'b1;
                    end else begin
                        pri_idx_d = idx_inc;
                    end
                end
            end
        endcase

        overrun_d = pri_edge && (state_q != IDLE);
        cpi_st_d  = (state_q == GAP) && (state_d == RX) && (pri_idx_q == '0);
        tx_gate_d = (state_d == TX);
        rx_win_d  = (state_d == RX);
        busy_d    = (state_d != IDLE);

        // Product is formed in 16 bits; the length check bounds it.
        tx_prod  = 16'((wc_d == '0) ? 8'd1 : wc_d) * 16'(TX_UNIT);
        seg_load = (state_d != state_q) && (state_d != IDLE);
        unique case (state_d)
            TX:      seg_val = CW'(tx_prod);
            GAP:     seg_val = GAP_CYC;
            default: seg_val = RX_CYC;
        endcase
    end

    always_ff @(posedge glb_100M) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pri_d_q   <= 1'b0;
            wc_q      <= '0;
            cpi_len_q <= 16'd1;
            pri_idx_q <= '0;
            tx_gate_q <= 1'b0;
            rx_win_q  <= 1'b0;
            cpi_st_q  <= 1'b0;
            cpi_end_q <= 1'b0;
            overrun_q <= 1'b0;
            hdr_err_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pri_d_q   <= PRI;
            wc_q      <= wc_d;
            cpi_len_q <= cpi_len_d;
            pri_idx_q <= pri_idx_d;
            tx_gate_q <= tx_gate_d;
            rx_win_q  <= rx_win_d;
            cpi_st_q  <= cpi_st_d;
            cpi_end_q <= cpi_end_d;
            overrun_q <= overrun_d;
            hdr_err_q <= hdr_err_d;
            busy_q    <= busy_d;
        end
    end

    seg_timer #(
        .CW(CW)
    ) u_seg_timer (
        .clk   (glb_100M),
        .rst_n (rst_n),
        .load  (seg_load),
        .value (seg_val),
        .done  (seg_done)
    );

    assign tx_gate = tx_gate_q;
    assign rx_win  = rx_win_q;
    assign cpi_st  = cpi_st_q;
    assign cpi_end = cpi_end_q;
    assign pri_idx = pri_idx_q;
    assign overrun = overrun_q;
    assign hdr_err = hdr_err_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_pri_sched.sv
// Scoreboard bench for pri_sched with short TX/GAP/RX timings.
// Stimulus queues expected edge events; a monitor matches them.
module tb_pri_sched;

    localparam int TXU = 10;
    localparam int DLY = 5;
    localparam int LEN = 20;

    localparam int K_TXR  = 0;
    localparam int K_TXF  = 1;
    localparam int K_RXR  = 2;
    localparam int K_RXF  = 3;
    localparam int K_CST  = 4;
    localparam int K_CEND = 5;
    localparam int K_OVR  = 6;
    localparam int K_HERR = 7;

    typedef struct {
        int kind;
        int cyc;
        int idx;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        PRI;
    logic        flag;
    logic [7:0]  work_mode;
    logic [7:0]  wave_code;
    logic [15:0] pri_code;
    logic        tx_gate, rx_win, cpi_st, cpi_end;
    logic [15:0] pri_idx;
    logic        overrun, hdr_err, busy;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   started = 0;
    ev_t  expq[$];
    int   m_idx = 0;
    int   m_len = 1;

    logic p_tx = 0, p_rx = 0;

    pri_sched #(
        .TX_UNIT(TXU),
        .RX_DLY (DLY),
        .RX_LEN (LEN),
        .CW     (16)
    ) dut (
        .glb_100M (clk),
        .rst_n    (rst_n),
        .PRI      (PRI),
        .flag     (flag),
        .work_mode(work_mode),
        .wave_code(wave_code),
        .pri_code (pri_code),
        .tx_gate  (tx_gate),
        .rx_win   (rx_win),
        .cpi_st   (cpi_st),
        .cpi_end  (cpi_end),
        .pri_idx  (pri_idx),
        .overrun  (overrun),
        .hdr_err  (hdr_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_TXR:   return "tx_rise";
            K_TXF:   return "tx_fall";
            K_RXR:   return "rx_rise";
            K_RXF:   return "rx_fall";
            K_CST:   return "cpi_st";
            K_CEND:  return "cpi_end";
            K_OVR:   return "overrun";
            default: return "hdr_err";
        endcase
    endfunction

    task automatic push(input int k, input int c, input int i);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.idx  = i;
        expq.push_back(e);
    endtask

    task automatic got(input int k, input int c, input int i);
        int j;
        j = -1;
        for (int n = 0; n < expq.size(); n++) begin
            if (j < 0 && expq[n].kind == k) j = n;
        end
        total++;
        if (j < 0) begin
            bad++;
            $display("FAIL %s: unexpected event at cycle %0d", kname(k), c);
        end else begin
            if (expq[j].cyc != c || (k == K_RXF && expq[j].idx != i)) begin
                bad++;
                $display("FAIL %s: got cycle %0d idx %0d, expected cycle %0d idx %0d",
                         kname(k), c, i, expq[j].cyc, expq[j].idx);
            end
            expq.delete(j);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            if (tx_gate && !p_tx) got(K_TXR, cyc, 0);
            if (!tx_gate && p_tx) got(K_TXF, cyc, 0);
            if (rx_win && !p_rx)  got(K_RXR, cyc, 0);
            if (!rx_win && p_rx)  got(K_RXF, cyc, int'(pri_idx));
            if (cpi_st)           got(K_CST, cyc, 0);
            if (cpi_end)          got(K_CEND, cyc, 0);
            if (overrun)          got(K_OVR, cyc, 0);
            if (hdr_err)          got(K_HERR, cyc, 0);
        end
        p_tx = tx_gate;
        p_rx = rx_win;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic at(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pri_pulse(input int t);
        at(t);
        PRI = 1'b1;
        at(t + 4);
        PRI = 1'b0;
    endtask

    // Expected events of one accepted PRI edge in cycle t.
    task automatic good(input int t, input int wc, input int pc);
        int n;
        n = ((wc == 0) ? 1 : wc) * TXU;
        if (m_idx == 0) m_len = (pc == 0) ? 1 : pc;
        push(K_TXR, t + 1, 0);
        push(K_TXF, t + n + 1, 0);
        push(K_RXR, t + n + DLY + 1, 0);
        if (m_idx == 0) push(K_CST, t + n + DLY + 1, 0);
        m_idx++;
        if (m_idx == m_len) begin
            m_idx = 0;
            push(K_CEND, t + n + DLY + LEN + 1, 0);
        end
        push(K_RXF, t + n + DLY + LEN + 1, m_idx);
    endtask

    task automatic bad_hdr(input int t);
        push(K_HERR, t + 1, 0);
        m_idx = 0;
    endtask

    initial begin
        rst_n     = 1'b0;
        PRI       = 1'b0;
        flag      = 1'b0;
        work_mode = 8'h01;
        wave_code = 8'd3;
        pri_code  = 16'd4;

        at(3);
        @(negedge clk);
        chk("rst_tx_gate", int'(tx_gate), 0);
        chk("rst_rx_win", int'(rx_win), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pri_idx", int'(pri_idx), 0);
        chk("rst_pulses", int'({cpi_st, cpi_end, overrun, hdr_err}), 0);
        started = 1;
        at(5);
        rst_n = 1'b1;

        good(10, 3, 4);
        pri_pulse(10);
        at(43);
        @(negedge clk);
        chk("gap_busy", int'(busy), 1);
        chk("gap_tx_off", int'(tx_gate), 0);
        at(70);
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);
        chk("idx_after_1", int'(pri_idx), 1);

        pri_code = 16'd7;
        good(110, 3, 7);
        pri_pulse(110);
        good(210, 3, 7);
        pri_pulse(210);
        good(310, 3, 7);
        pri_pulse(310);

        pri_code = 16'd4;
        good(410, 3, 4);
        pri_pulse(410);
        push(K_OVR, 451, 0);
        pri_pulse(450);
        at(470);
        @(negedge clk);
        chk("idx_after_ovr", int'(pri_idx), 1);

        good(510, 3, 4);
        pri_pulse(510);
        flag = 1'b1;
        bad_hdr(610);
        pri_pulse(610);
        at(613);
        @(negedge clk);
        chk("hdr_idx_clear", int'(pri_idx), 0);
        flag = 1'b0;
        good(710, 3, 4);
        pri_pulse(710);

        work_mode = 8'h04;
        bad_hdr(800);
        pri_pulse(800);
        work_mode = 8'h02;
        wave_code = 8'd0;
        pri_code  = 16'd0;
        good(900, 0, 0);
        pri_pulse(900);
        work_mode = 8'h03;
        good(1000, 0, 0);
        pri_pulse(1000);

        work_mode = 8'h01;
        wave_code = 8'd3;
        pri_code  = 16'd4;
        push(K_TXR, 1101, 0);
        push(K_TXF, 1131, 0);
        push(K_RXR, 1136, 0);
        push(K_CST, 1136, 0);
        push(K_RXF, 1141, 0);
        pri_pulse(1100);
        at(1140);
        rst_n = 1'b0;
        at(1141);
        @(negedge clk);
        chk("midrst_rx_win", int'(rx_win), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_idx", int'(pri_idx), 0);
        at(1143);
        rst_n = 1'b1;
        m_idx = 0;
        good(1200, 3, 4);
        pri_pulse(1200);

        at(1270);
        @(negedge clk);
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL missing_events: %0d left, first %s at cycle %0d",
                     expq.size(), kname(expq[0].kind), expq[0].cyc);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
